lustre_trace_fifo: RTL and testbench
====================================

Name: lustre_trace_fifo

Overview:
- Downstream capture stage for a compiled Lustre top module.
- Samples one node output stream once per enabled instant and tags each sample with an instant index and a first-instant flag.
- Buffers tagged samples in a FIFO and drains them to a testbench or debug sink over a valid/ready handshake.
- Sits beside the top wrapper: shares its clock, takes its `init` pulse and a node output such as `var_z`.

Parameters:
- N, 1, width of the sampled node output (same meaning as N on lustre_fby/lustre_not).
- DEPTH, 8, FIFO entries; power of two, >= 2.
- STEP_W, 16, width of the instant counter attached to each sample.

Ports:
- clock  input  1  single clock, all state updates on posedge.
- reset  input  1  synchronous, active-high; flushes all state.
- init  input  1  first-instant flag from the top wrapper (1 on the first instant after reset).
- sample_en  input  1  1 = record this cycle's instant.
- sample_val  input  N  node output value to record.
- out_valid  output  1  head entry available.
- out_ready  input  1  sink accepts head entry.
- out_data  output  N  head sample value.
- out_step  output  STEP_W  instant index of head sample.
- out_first  output  1  head sample was taken with init=1.
- count  output  $clog2(DEPTH)+1  current occupancy.
- full  output  1  count == DEPTH.
- overflow_cnt  output  8  samples dropped because the FIFO was full; saturates at 255.

Behaviour:
- Reset (synchronous, clock edge with reset=1) clears the following, overriding all same-cycle events:
  - wr/rd pointers = 0, count = 0, full = 0, out_valid = 0;
  - out_data/out_step/out_first read as 0 while empty;
  - step counter = 0, overflow_cnt = 0.
- Instant counter:
  - On each sample_en=1 cycle the recorded step is 0 if init=1, else step_reg.
  - step_reg <= recorded step + 1, wrapping modulo 2^STEP_W.
  - step_reg holds when sample_en=0.
- Push condition: sample_en=1 AND (count < DEPTH OR pop this cycle).
  - On push, the entry {recorded step, init, sample_val} is written at wr_ptr and wr_ptr advances.
- Pop condition: out_valid=1 AND out_ready=1; rd_ptr advances.
- Count update:
  - +1 on push only;
  - -1 on pop only;
  - unchanged on simultaneous push+pop.
- Full with no pop:
  - the sample is dropped and overflow_cnt increments (saturating);
  - the step counter still advances, so dropped instants leave a visible gap in out_step.
- Output timing and framing:
  - Show-ahead outputs: out_valid = (count != 0); out_* are driven from registered storage at rd_ptr.
  - A sample pushed at edge t appears on the outputs no earlier than after edge t (1-cycle latency). There is no same-cycle bypass, even when the FIFO is empty.
  - While out_valid=1 and out_ready=0, out_data/out_step/out_first hold stable.
  - out_valid never drops without a pop (except on reset).
- Pointer wrap:
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
  - full/empty are derived from count, not from pointer compare.
- init is sampled only on sample_en=1 cycles; init=1 with sample_en=0 has no effect.
- Reset mid-drain: all buffered entries are discarded and out_valid falls at that edge; no partial entry is emitted.

Decomposition:
- Shared include header lustre_defs.vh holds:
  - the overflow counter width (8) and saturation value;
  - the entry field packing order {step, first, data}.
- One natural sub-module: lustre_sync_fifo.
  - Parameters: WIDTH, DEPTH.
  - Ports: clock, reset, push, din, pop, dout, count.
  - Generic storage; reusable by other harness blocks.
- lustre_trace_fifo keeps the step counter, push gating, overflow counting and field packing.

Test Plan:
- Reset, then init=1 for one cycle, sample_en=1 continuously, sample_val toggling 0,1,0,1 (N=1), out_ready=1 → outputs, starting one cycle after each push:
  - out_data 0,1,0,1;
  - out_step 0,1,2,3;
  - out_first 1,0,0,0;
  - count never exceeds 1.
- out_ready=0, 10 samples, DEPTH=8:
  - full=1 after 8 pushes, overflow_cnt=2.
  - Then out_ready=1 with sample_en=0 → steps 0..7 drain in order and count reaches 0.
- Full FIFO, sample_en=1 and out_ready=1 together:
  - push and pop both occur, count stays 8, overflow_cnt unchanged;
  - the next drained step skips no value.
- Second init pulse at instant 5 → that entry has out_step=0, out_first=1; following entries are numbered 1,2,…
- STEP_W=4, 20 samples with out_ready=1 → out_step runs 0..15, then 0..3.
- Reset asserted with 5 entries buffered and out_ready=0:
  - next cycle count=0, out_valid=0, overflow_cnt=0;
  - the next sample (init=0) gets out_step=0.

Source files
------------

// File: rtl/lustre_trace_fifo_pkg.sv
// Package for the Lustre trace capture stage.
// Holds the overflow-counter constants, the FIFO operation encoding used by
// lustre_sync_fifo, and the saturating overflow-counter step function.
`include "lustre_defs.vh"

package lustre_trace_fifo_pkg;

    localparam int OVF_W = `LUSTRE_OVF_W;
    localparam logic [OVF_W-1:0] OVF_SAT = `LUSTRE_OVF_SAT;

    // {push, pop} viewed as a single operation code.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    // Next overflow count: increments on a drop, sticks at OVF_SAT.
    function automatic logic [OVF_W-1:0] ovf_next(input logic [OVF_W-1:0] cur,
                                                  input logic             drop);
        return (drop && (cur != OVF_SAT)) ? cur + 1'b1 : cur;
    endfunction

endpackage

// File: rtl/lustre_defs.vh
// Shared definitions for the Lustre capture/harness blocks.
//   - overflow counter width and saturation value
//   - trace entry field packing order: {step, first, data}
`ifndef LUSTRE_DEFS_VH
`define LUSTRE_DEFS_VH

`define LUSTRE_OVF_W   8
`define LUSTRE_OVF_SAT 8'hFF

// Entry layout, MSB to LSB: {step, first, data}. Data sits at bit 0, so the
// first flag lives at bit N and the step field starts at bit N+1.
`define LUSTRE_PACK(step, first, data) {(step), (first), (data)}
`define LUSTRE_FIRST_BIT(n)            (n)
`define LUSTRE_STEP_LSB(n)             ((n) + 1)

`endif

// File: rtl/lustre_sync_fifo.sv
// Generic synchronous show-ahead FIFO.
//   clock  : single clock, posedge
//   reset  : synchronous, active-high; clears pointers and occupancy
//   push   : write din at the tail (caller guarantees space or same-cycle pop)
//   din    : write data
//   pop    : advance the head (caller guarantees non-empty)
//   dout   : head entry, zero while empty
//   count  : occupancy, 0..DEPTH
// Occupancy is kept in an explicit counter; full/empty are derived from it
// rather than from pointer compare, so pointers simply wrap.
module lustre_sync_fifo
    import lustre_trace_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_q;
    fifo_op_e         op;

    assign op = fifo_op_e'({push, pop});

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case (op)
                OP_PUSH: count_q <= count_q + 1'b1;
                OP_POP:  count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: stale contents are masked while empty.
    always_ff @(posedge clock) begin
        if (!reset && push) mem[wr_ptr] <= din;
    end

    // Show-ahead read straight from registered storage; no write bypass, so
    // a freshly pushed entry becomes visible only after its write edge.
    assign dout  = (count_q != '0) ? mem[rd_ptr] : '0;
    assign count = count_q;

endmodule

// File: rtl/lustre_trace_fifo.sv
// Trace capture stage for a compiled Lustre top module.
// Records one node output per enabled instant, tags it with an instant index
// and a first-instant flag, buffers it and drains over valid/ready.
//   clock        : shared with the top wrapper
//   reset        : synchronous, active-high; flushes buffer and counters
//   init         : first-instant flag from the wrapper (sampled with sample_en)
//   sample_en    : record this cycle's instant
//   sample_val   : node output value to record
//   out_valid    : head entry available
//   out_ready    : sink accepts head entry
//   out_data     : head sample value
//   out_step     : head instant index
//   out_first    : head was recorded with init=1
//   count        : occupancy
//   full         : count == DEPTH
//   overflow_cnt : samples dropped on a full buffer, saturating
`include "lustre_defs.vh"

module lustre_trace_fifo
    import lustre_trace_fifo_pkg::*;
#(
    parameter int N      = 1,
    parameter int DEPTH  = 8,
    parameter int STEP_W = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    init,
    input  logic                    sample_en,
    input  logic [N-1:0]            sample_val,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N-1:0]            out_data,
    output logic [STEP_W-1:0]       out_step,
    output logic                    out_first,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic [OVF_W-1:0]        overflow_cnt
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = STEP_W + 1 + N;

    logic [STEP_W-1:0] step_reg;
    logic [STEP_W-1:0] rec_step;
    logic [OVF_W-1:0]  ovf_q;
    logic [EW-1:0]     wr_entry;
    logic [EW-1:0]     rd_entry;
    logic [CW-1:0]     occ;
    logic              push;
    logic              pop;
    logic              drop;

    // init restarts numbering for the sample taken in the same instant.
    assign rec_step = init ? '0 : step_reg;

    assign pop  = out_valid & out_ready;
    // A full buffer still accepts a sample when the head leaves this cycle.
    assign push = sample_en & (~full | pop);
    assign drop = sample_en & full & ~pop;

    assign wr_entry = `LUSTRE_PACK(rec_step, init, sample_val);

    // Step counter advances on every enabled instant, dropped or not, so
    // lost samples show up as gaps in out_step.
    always_ff @(posedge clock) begin
        if (reset) begin
            step_reg <= '0;
            ovf_q    <= '0;
        end else begin
            if (sample_en) step_reg <= rec_step + 1'b1;
            ovf_q <= ovf_next(ovf_q, drop);
        end
    end

    lustre_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .din   (wr_entry),
        .pop   (pop),
        .dout  (rd_entry),
        .count (occ)
    );

    assign count        = occ;
    assign full         = (occ == CW'(DEPTH));
    assign out_valid    = (occ != '0);
    assign out_data     = rd_entry[N-1:0];
    assign out_first    = rd_entry[`LUSTRE_FIRST_BIT(N)];
    assign out_step     = rd_entry[`LUSTRE_STEP_LSB(N) +: STEP_W];
    assign overflow_cnt = ovf_q;

endmodule

// File: tb/tb_lustre_trace_fifo.sv
module tb_lustre_trace_fifo;

    logic        clock;
    logic        reset;
    logic        init;
    logic        sample_en;
    logic [0:0]  sample_val;
    logic        out_ready;

    logic        out_valid;
    logic [0:0]  out_data;
    logic [15:0] out_step;
    logic        out_first;
    logic [3:0]  count;
    logic        full;
    logic [7:0]  overflow_cnt;

    logic        b_valid;
    logic [0:0]  b_data;
    logic [3:0]  b_step;
    logic        b_first;
    logic [3:0]  b_count;
    logic        b_full;
    logic [7:0]  b_ovf;

    int n_tests = 0;
    int n_fail  = 0;

    lustre_trace_fifo #(.N(1), .DEPTH(8), .STEP_W(16)) u_dut (
        .clock(clock), .reset(reset), .init(init), .sample_en(sample_en),
        .sample_val(sample_val), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_step(out_step), .out_first(out_first),
        .count(count), .full(full), .overflow_cnt(overflow_cnt)
    );

    lustre_trace_fifo #(.N(1), .DEPTH(8), .STEP_W(4)) u_dut4 (
        .clock(clock), .reset(reset), .init(init), .sample_en(sample_en),
        .sample_val(sample_val), .out_valid(b_valid), .out_ready(out_ready),
        .out_data(b_data), .out_step(b_step), .out_first(b_first),
        .count(b_count), .full(b_full), .overflow_cnt(b_ovf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; init = 1'b0; sample_en = 1'b0; sample_val = 1'b0; out_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();

        // reset state
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_count", {28'd0, count}, 32'd0);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_ovf", {24'd0, overflow_cnt}, 32'd0);
        chk("rst_step", {16'd0, out_step}, 32'd0);
        chk("rst_first", {31'd0, out_first}, 32'd0);
        chk("rst_data", {31'd0, out_data}, 32'd0);

        // streaming with out_ready=1: head is always the latest sample
        out_ready = 1'b1;
        sample_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            init = (i == 0);
            sample_val = 1'(i & 1);
            tick();
            chk("s1_valid", {31'd0, out_valid}, 32'd1);
            chk("s1_data", {31'd0, out_data}, i & 1);
            chk("s1_step", {16'd0, out_step}, i);
            chk("s1_first", {31'd0, out_first}, (i == 0) ? 1 : 0);
            chk("s1_count", {28'd0, count}, 32'd1);
        end
        init = 1'b0; sample_en = 1'b0;
        tick();
        chk("s1_empty", {31'd0, out_valid}, 32'd0);

        // fill past full with sink stalled
        out_ready = 1'b0;
        sample_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            init = (i == 0);
            sample_val = 1'(i & 1);
            tick();
            if (i == 7) begin
                chk("s2_full8", {31'd0, full}, 32'd1);
                chk("s2_count8", {28'd0, count}, 32'd8);
                chk("s2_ovf8", {24'd0, overflow_cnt}, 32'd0);
            end
        end
        init = 1'b0;
        chk("s2_ovf", {24'd0, overflow_cnt}, 32'd2);
        chk("s2_hold_step", {16'd0, out_step}, 32'd0);
        chk("s2_hold_first", {31'd0, out_first}, 32'd1);
        sample_en = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("s2_drain_valid", {31'd0, out_valid}, 32'd1);
            chk("s2_drain_step", {16'd0, out_step}, k);
            chk("s2_drain_data", {31'd0, out_data}, k & 1);
            chk("s2_drain_first", {31'd0, out_first}, (k == 0) ? 1 : 0);
            tick();
        end
        chk("s2_count0", {28'd0, count}, 32'd0);
        chk("s2_valid0", {31'd0, out_valid}, 32'd0);

        // full FIFO with simultaneous push and pop (steps continue from 10)
        out_ready = 1'b0;
        sample_en = 1'b1;
        sample_val = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("s3_full", {31'd0, full}, 32'd1);
        out_ready = 1'b1;
        tick();
        chk("s3_count", {28'd0, count}, 32'd8);
        chk("s3_ovf", {24'd0, overflow_cnt}, 32'd2);
        sample_en = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("s3_step", {16'd0, out_step}, 11 + k);
            chk("s3_step4", {28'd0, b_step}, (11 + k) & 15);
            tick();
        end
        chk("s3_empty", {28'd0, count}, 32'd0);

        // second init pulse at instant 5
        sample_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            init = (i == 0) || (i == 5);
            sample_val = 1'b0;
            tick();
            chk("s4_step", {16'd0, out_step}, (i < 5) ? i : i - 5);
            chk("s4_first", {31'd0, out_first}, ((i == 0) || (i == 5)) ? 1 : 0);
        end
        init = 1'b0; sample_en = 1'b0;
        tick();

        // step wrap on the STEP_W=4 instance
        sample_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            init = (i == 0);
            tick();
            chk("s5_step4", {28'd0, b_step}, i & 15);
            chk("s5_step16", {16'd0, out_step}, i);
        end
        init = 1'b0; sample_en = 1'b0;
        tick();

        // overflow saturation
        out_ready = 1'b0;
        sample_en = 1'b1;
        for (int i = 0; i < 268; i++) tick();
        chk("s6_ovf_sat", {24'd0, overflow_cnt}, 32'd255);
        chk("s6_ovf_sat4", {24'd0, b_ovf}, 32'd255);
        sample_en = 1'b0;
        out_ready = 1'b1;
        tick(); tick(); tick();
        out_ready = 1'b0;
        chk("s6_count5", {28'd0, count}, 32'd5);

        // reset mid-drain, overriding a same-cycle sample
        reset = 1'b1;
        sample_en = 1'b1;
        tick();
        reset = 1'b0;
        sample_en = 1'b0;
        chk("s6_rst_count", {28'd0, count}, 32'd0);
        chk("s6_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("s6_rst_ovf", {24'd0, overflow_cnt}, 32'd0);
        sample_en = 1'b1;
        init = 1'b0;
        sample_val = 1'b1;
        #1;
        chk("s6_no_bypass", {31'd0, out_valid}, 32'd0);
        tick();
        sample_en = 1'b0;
        chk("s6_post_valid", {31'd0, out_valid}, 32'd1);
        chk("s6_post_step", {16'd0, out_step}, 32'd0);
        chk("s6_post_first", {31'd0, out_first}, 32'd0);
        chk("s6_post_data", {31'd0, out_data}, 32'd1);
        chk("s6_post_count", {28'd0, count}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
